// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchronized input, mid-bit sampling, one-deep output holding register.
// Optional even parity bit between data and stop when UART_RX_PARITY_EN is defined.
module uart_rx_core #(
  parameter int CLOCK_COUNTER_WIDTH = 10,
  parameter int BIT_COUNTER_WIDTH   = 3,
  parameter int DATA_WIDTH          = 8,
  parameter int CLOCKS_PER_BIT      = 434
) (
  input  logic                  i_clock,
  input  logic                  i_resetL,
  input  logic                  i_RX,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_frame_error,
  output logic                  o_overrun,
`ifdef UART_RX_PARITY_EN
  output logic                  o_parity_error,
`endif
  output logic                  o_busy
);

  localparam logic [CLOCK_COUNTER_WIDTH-1:0] HALF_BIT = CLOCK_COUNTER_WIDTH'(CLOCKS_PER_BIT / 2);
  localparam logic [CLOCK_COUNTER_WIDTH-1:0] LAST_TICK = CLOCK_COUNTER_WIDTH'(CLOCKS_PER_BIT - 1);
  localparam logic [BIT_COUNTER_WIDTH-1:0] LAST_BIT = BIT_COUNTER_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_t;

  state_t                   state, state_next;
  logic                     rx_meta, rx_sync, rx_prev;
  logic [CLOCK_COUNTER_WIDTH-1:0] clk_count;
  logic [BIT_COUNTER_WIDTH-1:0]   bit_count;
  logic [DATA_WIDTH-1:0]    shift_reg;
  logic                     bit_tick, rx_fall, stop_ok, stop_bad, drop_byte;
  logic                     par_bad, par_bad_now;

  assign bit_tick = (clk_count == LAST_TICK);
  assign rx_fall  = rx_prev & ~rx_sync;
  assign o_busy   = (state != IDLE);

  always_ff @(posedge i_clock or negedge i_resetL) begin
    if (!i_resetL) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge i_clock or negedge i_resetL) begin
    if (!i_resetL) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next  = state;
    stop_ok     = 1'b0;
    stop_bad    = 1'b0;
    par_bad_now = 1'b0;
    case (state)
      IDLE:      if (rx_fall) state_next = START;
      START:     if (clk_count == HALF_BIT) state_next = rx_sync ? IDLE : DATA;
      DATA: begin
        if (bit_tick && (bit_count == LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          state_next  = STOP;
          par_bad_now = (rx_sync != ^shift_reg);
        end
      end
`endif
      STOP: begin
        if (bit_tick) begin
          state_next = rx_sync ? IDLE : WAIT_IDLE;
          stop_ok    = rx_sync & ~par_bad;
          stop_bad   = ~rx_sync;
        end
      end
      WAIT_IDLE: if (rx_sync) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Counter restarts on every state change and wraps once per bit period.
  always_ff @(posedge i_clock or negedge i_resetL) begin
    if (!i_resetL) begin
      clk_count <= '0;
      bit_count <= '0;
      shift_reg <= '0;
      par_bad   <= 1'b0;
    end else begin
      if ((state == IDLE) || (state == WAIT_IDLE) || (state_next != state) || bit_tick)
        clk_count <= '0;
      else
        clk_count <= clk_count + 1'b1;

      if (state != DATA)  bit_count <= '0;
      else if (bit_tick)  bit_count <= bit_count + 1'b1;

      if ((state == DATA) && bit_tick)
        shift_reg <= {rx_sync, shift_reg[DATA_WIDTH-1:1]};

      if (state == IDLE)    par_bad <= 1'b0;
      else if (par_bad_now) par_bad <= 1'b1;
    end
  end

  // A completed byte is dropped only when the held byte is not being consumed this cycle.
  assign drop_byte = o_valid & ~i_ready;

  always_ff @(posedge i_clock or negedge i_resetL) begin
    if (!i_resetL) begin
      o_data        <= '0;
      o_valid       <= 1'b0;
      o_frame_error <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      o_frame_error <= stop_bad;
      o_overrun     <= stop_ok & drop_byte;
      if (stop_ok && !drop_byte) begin
        o_data  <= shift_reg;
        o_valid <= 1'b1;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge i_clock or negedge i_resetL) begin
    if (!i_resetL) o_parity_error <= 1'b0;
    else           o_parity_error <= par_bad_now;
  end
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: drives serial frames and compares delivered bytes and
// error pulses with a frame-level expectation model.
`timescale 1ns/1ps
module tb_uart_rx_core;
  localparam int CPB = 434;

  logic       i_clock = 1'b0;
  logic       i_resetL = 1'b0;
  logic       i_RX = 1'b1;
  logic       i_ready = 1'b0;
  logic [7:0] o_data;
  logic       o_valid, o_frame_error, o_overrun, o_busy;
`ifdef UART_RX_PARITY_EN
  logic       o_parity_error;
  logic       par_inject_bad = 1'b0;
  int         pe_cnt = 0;
`endif

  int         checks = 0;
  int         errors = 0;
  logic [7:0] got_q[$];
  int         fe_cnt = 0, ov_cnt = 0, vld_cycles = 0;

  uart_rx_core dut (
    .i_clock       (i_clock),
    .i_resetL      (i_resetL),
    .i_RX          (i_RX),
    .i_ready       (i_ready),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .o_frame_error (o_frame_error),
    .o_overrun     (o_overrun),
`ifdef UART_RX_PARITY_EN
    .o_parity_error(o_parity_error),
`endif
    .o_busy        (o_busy)
  );

  always #5 i_clock = ~i_clock;

  // Observer: consumed bytes and pulse counts, sampled mid-cycle.
  always @(negedge i_clock) begin
    if (o_valid && i_ready) got_q.push_back(o_data);
    if (o_valid) vld_cycles++;
    if (o_frame_error) fe_cnt++;
    if (o_overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
    if (o_parity_error) pe_cnt++;
`endif
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge i_clock);
    #1;
  endtask

  task automatic clear_mon();
    got_q.delete();
    fe_cnt = 0; ov_cnt = 0; vld_cycles = 0;
`ifdef UART_RX_PARITY_EN
    pe_cnt = 0;
`endif
  endtask

  task automatic send_bit(input logic b);
    i_RX = b;
    tick(CPB);
  endtask

  // Line is left at the stop-bit level; caller decides what follows.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_inject_bad);
`endif
    send_bit(stop_bit);
  endtask

  task automatic test_reset();
    i_resetL = 1'b0;
    i_RX = 1'b0;
    tick(5);
    i_RX = 1'b1;
    tick(5);
    checks++;
    if (o_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", o_data); end
    checks++;
    if ({o_valid, o_frame_error, o_overrun, o_busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {o_valid, o_frame_error, o_overrun, o_busy});
    end
    i_resetL = 1'b1;
    tick(5);
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b expected 0", o_busy); end
  endtask

  task automatic test_basic();
    i_ready = 1'b1;
    clear_mon();
    send_frame(8'h55, 1'b1);
    tick(CPB);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h55) begin
      errors++; $display("FAIL basic_data: got %0d bytes first %h expected 1 byte 55", got_q.size(), got_q[0]);
    end
    checks++;
    if (vld_cycles != 1) begin errors++; $display("FAIL basic_valid_cycles: got %0d expected 1", vld_cycles); end
    checks++;
    if (fe_cnt != 0 || ov_cnt != 0) begin
      errors++; $display("FAIL basic_errors: got fe=%0d ov=%0d expected 0 0", fe_cnt, ov_cnt);
    end
  endtask

  task automatic test_glitch();
    int busy_cyc;
    busy_cyc = 0;
    clear_mon();
    for (int i = 0; i < 700; i++) begin
      i_RX = (i < 100) ? 1'b0 : 1'b1;
      tick(1);
      if (o_busy) busy_cyc++;
    end
    checks++;
    if (busy_cyc == 0 || busy_cyc >= 220) begin
      errors++; $display("FAIL glitch_busy_cycles: got %0d expected 1..219", busy_cyc);
    end
    checks++;
    if (vld_cycles != 0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL glitch_no_output: got vld=%0d busy=%b expected 0 0", vld_cycles, o_busy);
    end
  endtask

  task automatic test_frame_error();
    i_ready = 1'b1;
    clear_mon();
    send_frame(8'hA3, 1'b0);
    tick(2000);
    checks++;
    if (o_busy !== 1'b1) begin errors++; $display("FAIL fe_wait_busy: got %b expected 1", o_busy); end
    checks++;
    if (fe_cnt != 1 || vld_cycles != 0) begin
      errors++; $display("FAIL fe_pulse: got fe=%0d vld=%0d expected 1 0", fe_cnt, vld_cycles);
    end
    i_RX = 1'b1;
    tick(10);
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL fe_release_idle: got %b expected 0", o_busy); end
    tick(CPB);
    checks++;
    if (o_busy !== 1'b0 || vld_cycles != 0 || fe_cnt != 1) begin
      errors++; $display("FAIL fe_no_restart: got busy=%b vld=%0d fe=%0d expected 0 0 1", o_busy, vld_cycles, fe_cnt);
    end
  endtask

  task automatic test_overrun();
    i_ready = 1'b0;
    clear_mon();
    send_frame(8'h12, 1'b1);
    tick(CPB);
    send_frame(8'h34, 1'b1);
    tick(CPB);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h12) begin
      errors++; $display("FAIL ovr_hold: got valid=%b data=%h expected 1 12", o_valid, o_data);
    end
    checks++;
    if (ov_cnt != 1) begin errors++; $display("FAIL ovr_pulse: got %0d expected 1", ov_cnt); end
    i_ready = 1'b1;
    tick(1);
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain: got valid=%b expected 0", o_valid); end
    tick(2);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h12) begin
      errors++; $display("FAIL ovr_consumed: got %0d bytes first %h expected 1 byte 12", got_q.size(), got_q[0]);
    end
  endtask

  task automatic test_reset_mid_frame();
    i_ready = 1'b1;
    clear_mon();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    i_resetL = 1'b0;
    i_RX = 1'b1;
    tick(3);
    checks++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_in_reset: got busy=%b valid=%b expected 0 0", o_busy, o_valid);
    end
    tick(20);
    i_resetL = 1'b1;
    tick(CPB);
    send_frame(8'h7E, 1'b1);
    tick(CPB);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h7E || fe_cnt != 0) begin
      errors++; $display("FAIL midrst_deliver: got %0d bytes first %h fe=%0d expected 1 byte 7e fe=0", got_q.size(), got_q[0], fe_cnt);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] d;
    logic       good;
    int         exp_fe;
    exp_fe = 0;
    i_ready = 1'b1;
    clear_mon();
    for (int n = 0; n < 6; n++) begin
      d = 8'($urandom);
      good = ($urandom_range(0, 3) != 0);
      send_frame(d, good);
      if (good) exp_q.push_back(d);
      else exp_fe++;
      i_RX = 1'b1;
      tick(CPB + $urandom_range(0, 200));
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rand_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (fe_cnt != exp_fe || ov_cnt != 0) begin
      errors++; $display("FAIL rand_errors: got fe=%0d ov=%0d expected %0d 0", fe_cnt, ov_cnt, exp_fe);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    i_ready = 1'b1;
    clear_mon();
    par_inject_bad = 1'b1;
    send_frame(8'h07, 1'b1);
    par_inject_bad = 1'b0;
    tick(CPB);
    checks++;
    if (pe_cnt != 1 || vld_cycles != 0 || fe_cnt != 0) begin
      errors++; $display("FAIL parity_bad: got pe=%0d vld=%0d fe=%0d expected 1 0 0", pe_cnt, vld_cycles, fe_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
